// File: rtl/tdm_demultiplexer_if.sv
// Purpose: bundles the serial TDM input and the demultiplexed slot-word outputs.
// Latency: none, wiring only.
// Backpressure: none; the stream is qualified by inValid, there is no ready path.
interface tdm_demultiplexer_if #(
    parameter int WIDTH = 8
);
    logic             in;
    logic             inValid;
    logic             sync;
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
    logic             outValid;
    logic             address0;
    logic             syncError;

    // Stream source side: drives the serial bits, observes the words.
    modport master (
        output in, inValid, sync,
        input  out0, out1, outValid, address0, syncError
    );

    // Demultiplexer side.
    modport slave (
        input  in, inValid, sync,
        output out0, out1, outValid, address0, syncError
    );
endinterface

// File: rtl/tdm_demultiplexer.sv
// Purpose: splits a two-slot MSB-first serial TDM stream into slot-0/slot-1 words.
// Latency: last slot-1 bit sampled on edge N -> out0/out1 and outValid visible after edge N.
// Backpressure: none; inValid=0 freezes all state, the sink must accept every outValid.
module tdm_demultiplexer #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    tdm_demultiplexer_if.slave  bus
);
    localparam int              CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic               slot;
    logic [WIDTH-1:0]   shift0;
    logic [WIDTH-1:0]   shift1;
    logic [WIDTH-1:0]   out0_q;
    logic [WIDTH-1:0]   out1_q;
    logic               out_valid_q;
    logic               sync_error_q;
    logic               at_frame_start;

    // A sync is legitimate only where a slot-0 MSB is expected; in RECV that
    // position is never reached, so every sync seen in RECV is a violation.
    assign at_frame_start = (slot == 1'b0) && (bit_cnt == '0);

    // Framing FSM, bit counter, slot shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= HUNT;
            bit_cnt      <= '0;
            slot         <= 1'b0;
            shift0       <= '0;
            shift1       <= '0;
            out0_q       <= '0;
            out1_q       <= '0;
            out_valid_q  <= 1'b0;
            sync_error_q <= 1'b0;
        end else begin
            out_valid_q  <= 1'b0;
            sync_error_q <= 1'b0;
            if (bus.inValid) begin
                if (bus.sync) begin
                    // New frame: this bit is the slot-0 MSB; any partial frame is dropped.
                    shift0       <= {{(WIDTH-1){1'b0}}, bus.in};
                    bit_cnt      <= CNT_W'(1);
                    slot         <= 1'b0;
                    state        <= RECV;
                    sync_error_q <= (state == RECV) && !at_frame_start;
                end else if (state == RECV) begin
                    if (slot == 1'b0) begin
                        shift0 <= {shift0[WIDTH-2:0], bus.in};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            slot    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else begin
                        shift1 <= {shift1[WIDTH-2:0], bus.in};
                        if (bit_cnt == LAST_BIT) begin
                            // shift0 has been the slot-0 shadow since its last bit;
                            // both words are published together here.
                            out0_q      <= shift0;
                            out1_q      <= {shift1[WIDTH-2:0], bus.in};
                            out_valid_q <= 1'b1;
                            bit_cnt     <= '0;
                            slot        <= 1'b0;
                            state       <= HUNT;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
            end
        end
    end

    assign bus.out0      = out0_q;
    assign bus.out1      = out1_q;
    assign bus.outValid  = out_valid_q;
    assign bus.address0  = slot;
    assign bus.syncError = sync_error_q;
endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Purpose: self-checking bench for tdm_demultiplexer against a frame-level model.
// Latency: model predicts outputs visible after each rising edge; compared on the falling edge.
// Backpressure: none; stimulus drives inValid gaps and junk while idle.
module tb_tdm_demultiplexer;
    localparam int W = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tdm_demultiplexer_if #(.WIDTH(W)) bus ();

    tdm_demultiplexer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: collect valid bits since the last sync, assemble both
    // words once 2*W bits have arrived.
    bit             hunting = 1'b1;
    int             n       = 0;
    bit             frame_bits [0:2*W-1];
    logic [W-1:0]   e_out0  = '0;
    logic [W-1:0]   e_out1  = '0;
    bit             e_ov    = 1'b0;
    bit             e_se    = 1'b0;
    bit             e_addr  = 1'b0;
    bit             model_live = 1'b0;

    // Model update on every rising edge from the inputs presented in that cycle.
    always @(posedge clk) begin
        model_live = 1'b1;
        e_ov = 1'b0;
        e_se = 1'b0;
        if (reset) begin
            hunting = 1'b1;
            n       = 0;
            e_out0  = '0;
            e_out1  = '0;
        end else if (bus.inValid === 1'b1) begin
            if (bus.sync) begin
                if (!hunting) e_se = 1'b1;
                hunting       = 1'b0;
                frame_bits[0] = bus.in;
                n             = 1;
            end else if (!hunting) begin
                frame_bits[n] = bus.in;
                n++;
                if (n == 2*W) begin
                    for (int i = 0; i < W; i++) begin
                        e_out0 = {e_out0[W-2:0], frame_bits[i]};
                        e_out1 = {e_out1[W-2:0], frame_bits[W+i]};
                    end
                    e_ov    = 1'b1;
                    hunting = 1'b1;
                    n       = 0;
                end
            end
        end
        e_addr = !hunting && (n >= W);
    end

    int ov_cnt  = 0;
    int se_cnt  = 0;
    int cyc_no  = 0;
    int last_ov = 0;
    int prev_ov = 0;

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        if (model_live) begin
            cyc_no++;
            check("out0",      32'(bus.out0),      32'(e_out0));
            check("out1",      32'(bus.out1),      32'(e_out1));
            check("outValid",  32'(bus.outValid),  32'(e_ov));
            check("syncError", 32'(bus.syncError), 32'(e_se));
            check("address0",  32'(bus.address0),  32'(e_addr));
            if (bus.outValid === 1'b1) begin
                ov_cnt++;
                prev_ov = last_ov;
                last_ov = cyc_no;
            end
            if (bus.syncError === 1'b1) se_cnt++;
        end
    end

    logic [2*W-1:0] addr_log = '0;

    task automatic cyc(input bit v, input bit s, input bit b);
        @(negedge clk);
        #1;
        bus.inValid = v;
        bus.sync    = s;
        bus.in      = b;
    endtask

    // Sends the first nbits of frame f (slot 0 in the upper half), sync on bit 0.
    task automatic send_bits(input logic [2*W-1:0] f, input int nbits, input bit gaps);
        for (int i = 0; i < nbits; i++) begin
            if (gaps && i != 0) cyc(1'b0, 1'($urandom), 1'($urandom));
            cyc(1'b1, i == 0, f[2*W-1-i]);
            addr_log = {addr_log[2*W-2:0], bus.address0};
        end
    endtask

    int base_ov;
    int base_se;
    int pos;

    initial begin
        bus.inValid = 1'b0;
        bus.sync    = 1'b0;
        bus.in      = 1'b0;

        // Reset state
        repeat (3) cyc(1'b1, 1'b1, 1'b1);
        check("rst_out0",     32'(bus.out0),      32'h0);
        check("rst_out1",     32'(bus.out1),      32'h0);
        check("rst_outValid", 32'(bus.outValid),  32'h0);
        check("rst_addr",     32'(bus.address0),  32'h0);
        check("rst_syncErr",  32'(bus.syncError), 32'h0);
        cyc(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);

        // Contiguous frame A5/3C
        send_bits({8'hA5, 8'h3C}, 2*W, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("f1_ov_latency", 32'(bus.outValid), 32'h1);
        check("f1_out0",       32'(bus.out0),     32'hA5);
        check("f1_out1",       32'(bus.out1),     32'h3C);
        check("f1_addr_seq",   32'(addr_log),     32'h00FF);
        cyc(1'b0, 1'b0, 1'b0);
        check("f1_ov_pulse_end", 32'(bus.outValid), 32'h0);
        check("f1_ov_count",     32'(ov_cnt),       32'd1);

        // Same frame with inValid gaps
        base_ov = ov_cnt;
        base_se = se_cnt;
        send_bits({8'hA5, 8'h3C}, 2*W, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        check("f2_ov_latency", 32'(bus.outValid),      32'h1);
        check("f2_out0",       32'(bus.out0),          32'hA5);
        check("f2_out1",       32'(bus.out1),          32'h3C);
        check("f2_addr_seq",   32'(addr_log),          32'h00FF);
        check("f2_se_none",    32'(se_cnt - base_se),  32'd0);
        cyc(1'b0, 1'b0, 1'b0);
        check("f2_ov_count",   32'(ov_cnt - base_ov),  32'd1);

        // Back-to-back frames
        base_ov = ov_cnt;
        send_bits({8'h11, 8'h22}, 2*W, 1'b0);
        send_bits({8'h33, 8'h44}, 2*W, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("b2b_out0",    32'(bus.out0),          32'h33);
        check("b2b_out1",    32'(bus.out1),          32'h44);
        check("b2b_ov_cnt",  32'(ov_cnt - base_ov),  32'd2);
        check("b2b_spacing", 32'(last_ov - prev_ov), 32'd16);

        // Sync on the final slot-1 bit is a violation
        base_ov = ov_cnt;
        base_se = se_cnt;
        send_bits({8'hC7, 8'h18}, 2*W-1, 1'b0);
        send_bits({8'hE1, 8'h0F}, 2*W, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("late_sync_se",   32'(se_cnt - base_se), 32'd1);
        check("late_sync_ov",   32'(ov_cnt - base_ov), 32'd1);
        check("late_sync_out0", 32'(bus.out0),         32'hE1);
        check("late_sync_out1", 32'(bus.out1),         32'h0F);

        // Resync on bit 5 of slot 1, new frame FF/00
        base_ov = ov_cnt;
        base_se = se_cnt;
        send_bits({8'h12, 8'h34}, W + 4, 1'b0);
        send_bits({8'hFF, 8'h00}, 2*W, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("resync_se",   32'(se_cnt - base_se), 32'd1);
        check("resync_ov",   32'(ov_cnt - base_ov), 32'd1);
        check("resync_out0", 32'(bus.out0),         32'hFF);
        check("resync_out1", 32'(bus.out1),         32'h00);

        // Reset mid-frame on slot-1 bit 3, junk without sync, then 5A/C3
        base_ov = ov_cnt;
        send_bits({8'h77, 8'h66}, W + 3, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        reset = 1'b1;
        cyc(1'b1, 1'b0, 1'b1);
        reset = 1'b0;
        check("mid_rst_out0", 32'(bus.out0),     32'h0);
        check("mid_rst_out1", 32'(bus.out1),     32'h0);
        check("mid_rst_addr", 32'(bus.address0), 32'h0);
        for (int i = 0; i < W; i++) cyc(1'b1, 1'b0, 1'($urandom));
        cyc(1'b0, 1'b0, 1'b0);
        check("junk_out0",  32'(bus.out0),          32'h0);
        check("junk_ov",    32'(ov_cnt - base_ov),  32'd0);
        send_bits({8'h5A, 8'hC3}, 2*W, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("post_rst_out0", 32'(bus.out0),         32'h5A);
        check("post_rst_out1", 32'(bus.out1),         32'hC3);
        check("post_rst_ov",   32'(ov_cnt - base_ov), 32'd1);

        // Randomized stream: mostly well-formed frames with gaps, stray syncs, resets
        base_ov = ov_cnt;
        pos = 0;
        for (int k = 0; k < 3000; k++) begin
            bit v;
            bit s;
            bit b;
            v = ($urandom_range(0, 3) != 0);
            b = 1'($urandom);
            if (v) begin
                if (pos == 0) s = ($urandom_range(0, 7) != 0);
                else          s = ($urandom_range(0, 40) == 0);
                pos = s ? 1 : ((pos == 0) ? 0 : (pos + 1) % (2*W));
            end else begin
                s = 1'($urandom);
            end
            cyc(v, s, b);
            reset = ($urandom_range(0, 299) == 0);
            if (reset) pos = 0;
        end
        reset = 1'b0;
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        check("rand_frames_seen", 32'(ov_cnt - base_ov > 20), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
